// File: rtl/pixel_vector_loader_pkg.sv
// Shared types for the pixel vector loader: FSM state encoding and stall counter width.
package vload_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } vload_state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pixel_vector_loader_if.sv
// Valid/ready vector stream from the loader to the vector register file load path.
interface pixel_vector_loader_if #(
    parameter int WIDTH = 24,
    parameter int LANES = 4
);
    logic [LANES*WIDTH-1:0] vec_data;
    logic [LANES-1:0]       vec_mask;
    logic                   vec_valid;
    logic                   vec_ready;

    modport master (
        output vec_data,
        output vec_mask,
        output vec_valid,
        input  vec_ready
    );

    modport slave (
        input  vec_data,
        input  vec_mask,
        input  vec_valid,
        output vec_ready
    );
endinterface

// File: rtl/pixel_vector_loader_addr_gen.sv
// ROM address walker: latches base/count, wraps at DEPTH-1, tracks pixels still to fetch.
module vload_addr_gen #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] base_addr,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] remaining,
    output logic             last,
    output logic             empty
);
    logic [WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] addr_next;

    always_comb begin
        addr_next = addr_reg + WIDTH'(1);
        if (addr_reg == WIDTH'(DEPTH - 1)) begin
            addr_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= '0;
            rem_reg  <= '0;
        end else if (load) begin
            // Out-of-range base addresses restart the sweep at word 0.
            addr_reg <= (base_addr >= WIDTH'(DEPTH)) ? '0 : base_addr;
            rem_reg  <= count;
        end else if (step) begin
            addr_reg <= addr_next;
            rem_reg  <= rem_reg - WIDTH'(1);
        end
    end

    assign addr      = addr_reg;
    assign remaining = rem_reg;
    assign last      = (rem_reg == WIDTH'(1));
    assign empty     = (rem_reg == '0);
endmodule

// File: rtl/pixel_vector_loader.sv
// Sweeps a ROM window and packs pixels into LANES-wide vectors on a valid/ready stream.
// Optional VLOAD_STALL_CNT_EN adds a saturating count of back-pressured HOLD cycles.
module pixel_vector_loader
    import vload_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 24,
    parameter int LANES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          base_addr,
    input  logic [WIDTH-1:0]          count,
    output logic [WIDTH-1:0]          mem_addr,
    input  logic [WIDTH-1:0]          mem_rd,
    pixel_vector_loader_if.master     vec,
    output logic                      busy,
    output logic                      done
`ifdef VLOAD_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]    stall_cnt
`endif
);
    localparam int IDX_W = $clog2(LANES + 1);

    vload_state_t      state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [WIDTH-1:0]  lane_reg [LANES];
    logic [LANES-1:0]  mask_reg;
    logic              valid_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              start_acc;
    logic              fetch_step;
    logic              handshake;
    logic              addr_last;
    logic              addr_empty;
    logic [WIDTH-1:0]  remaining;
    logic [LANES*WIDTH-1:0] vec_data_w;

    assign start_acc  = (state_reg == IDLE) && start;
    assign fetch_step = (state_reg == FETCH);
    assign handshake  = (state_reg == HOLD) && valid_reg && vec.vec_ready;

    vload_addr_gen #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (start_acc),
        .step      (fetch_step),
        .base_addr (base_addr),
        .count     (count),
        .addr      (mem_addr),
        .remaining (remaining),
        .last      (addr_last),
        .empty     (addr_empty)
    );

    // Lane buffer: filled one lane per FETCH cycle, wiped by reset or an accepted vector
    // so a short final vector carries zeros in its unused lanes.
    always_ff @(posedge clk) begin
        if (rst || handshake) begin
            for (int i = 0; i < LANES; i++) begin
                lane_reg[i] <= '0;
            end
            mask_reg <= '0;
        end else if (fetch_step) begin
            for (int i = 0; i < LANES; i++) begin
                if (idx_reg == IDX_W'(i)) begin
                    lane_reg[i] <= mem_rd;
                    mask_reg[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        idx_reg  <= '0;
                        busy_reg <= 1'b1;
                        if (count == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    idx_reg <= idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_W'(LANES - 1) || addr_last) begin
                        state_reg <= HOLD;
                        valid_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    if (vec.vec_ready) begin
                        valid_reg <= 1'b0;
                        idx_reg   <= '0;
                        if (addr_empty) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_out
            assign vec_data_w[gi*WIDTH +: WIDTH] = lane_reg[gi];
        end
    endgenerate

    assign vec.vec_data  = vec_data_w;
    assign vec.vec_mask  = mask_reg;
    assign vec.vec_valid = valid_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

`ifdef VLOAD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_cnt_reg <= '0;
        end else if (state_reg == HOLD && !vec.vec_ready && stall_cnt_reg != '1) begin
            stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

    logic unused_ok;
    assign unused_ok = ^remaining;
endmodule

// File: tb/tb_pixel_vector_loader.sv
// Directed bench for pixel_vector_loader with a ROM model ROM[i] = 0x100 + i.
module tb_pixel_vector_loader;
    localparam int WIDTH = 24;
    localparam int DEPTH = 24;
    localparam int LANES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] base_addr;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rd;
    logic             busy;
    logic             done;
`ifdef VLOAD_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    pixel_vector_loader_if #(.WIDTH(WIDTH), .LANES(LANES)) vif ();

    pixel_vector_loader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LANES (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .vec       (vif.master),
        .busy      (busy),
        .done      (done)
`ifdef VLOAD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rd = (mem_addr < WIDTH'(DEPTH)) ? (24'h100 + mem_addr) : '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        count     = c;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!vif.vec_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 128'(vif.vec_valid), 128'd1);
        $display("vec %s data=%h mask=%b addr=%0h", tag, vif.vec_data, vif.vec_mask, mem_addr);
    endtask

    initial begin
        int n;
        int done_cnt;
        logic quiet;

        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; vif.vec_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",  128'(busy), 128'd0);
        check("rst_done",  128'(done), 128'd0);
        check("rst_valid", 128'(vif.vec_valid), 128'd0);
        check("rst_addr",  128'(mem_addr), 128'd0);
        check("rst_data",  128'(vif.vec_data), 128'd0);
        check("rst_mask",  128'(vif.vec_mask), 128'd0);

        // single full vector
        do_start(24'd0, 24'd4);
        wait_valid("t1", n);
        check("t1_latency", 128'(n), 128'd4);
        check("t1_data", 128'(vif.vec_data), 128'({24'h103, 24'h102, 24'h101, 24'h100}));
        check("t1_mask", 128'(vif.vec_mask), 128'(4'b1111));
        @(negedge clk);
        check("t1_done",  128'(done), 128'd1);
        check("t1_vdrop", 128'(vif.vec_valid), 128'd0);
        @(negedge clk);
        check("t1_done_end", 128'(done), 128'd0);
        check("t1_busy_end", 128'(busy), 128'd0);

        // full vector then partial vector
        do_start(24'd0, 24'd6);
        wait_valid("t2a", n);
        check("t2a_data", 128'(vif.vec_data), 128'({24'h103, 24'h102, 24'h101, 24'h100}));
        check("t2a_mask", 128'(vif.vec_mask), 128'(4'b1111));
        @(negedge clk);
        check("t2_mid_done", 128'(done), 128'd0);
        wait_valid("t2b", n);
        check("t2b_latency", 128'(n), 128'd2);
        check("t2b_data", 128'(vif.vec_data), 128'({24'h0, 24'h0, 24'h105, 24'h104}));
        check("t2b_mask", 128'(vif.vec_mask), 128'(4'b0011));
        done_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("t2_done_cnt", 128'(done_cnt), 128'd1);

        // address wrap 23 -> 0
        do_start(24'd22, 24'd4);
        wait_valid("t3", n);
        check("t3_data", 128'(vif.vec_data), 128'({24'h101, 24'h100, 24'h117, 24'h116}));
        check("t3_mask", 128'(vif.vec_mask), 128'(4'b1111));
        repeat (3) @(negedge clk);

        // back-pressure for 10 cycles in HOLD
        vif.vec_ready = 1'b0;
        do_start(24'd5, 24'd4);
        wait_valid("t4", n);
        repeat (10) @(negedge clk);
        check("t4_valid_held", 128'(vif.vec_valid), 128'd1);
        check("t4_data", 128'(vif.vec_data), 128'({24'h108, 24'h107, 24'h106, 24'h105}));
        check("t4_addr", 128'(mem_addr), 128'd9);
`ifdef VLOAD_STALL_CNT_EN
        check("t4_stall", 128'(stall_cnt), 128'd10);
`endif
        vif.vec_ready = 1'b1;
        @(negedge clk);
        check("t4_done", 128'(done), 128'd1);
        repeat (2) @(negedge clk);

        // zero-length transfer
        do_start(24'd3, 24'd0);
        check("t5_busy", 128'(busy), 128'd1);
        check("t5_done", 128'(done), 128'd1);
        check("t5_valid", 128'(vif.vec_valid), 128'd0);
        @(negedge clk);
        check("t5_busy_end", 128'(busy), 128'd0);
        check("t5_done_end", 128'(done), 128'd0);
        check("t5_valid_end", 128'(vif.vec_valid), 128'd0);
        $display("xfer t5 count=0 complete");

        // start while busy is ignored, then reset mid-transfer
        do_start(24'd10, 24'd8);
        check("t6_addr0", 128'(mem_addr), 128'd10);
        start = 1'b1; base_addr = 24'd0; count = 24'd2;
        @(negedge clk);
        check("t6_addr1", 128'(mem_addr), 128'd11);
        start = 1'b0;
        @(negedge clk);
        check("t6_addr2", 128'(mem_addr), 128'd12);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("t6_busy",  128'(busy), 128'd0);
        check("t6_done",  128'(done), 128'd0);
        check("t6_valid", 128'(vif.vec_valid), 128'd0);
        check("t6_addr",  128'(mem_addr), 128'd0);
        check("t6_data",  128'(vif.vec_data), 128'd0);
        check("t6_mask",  128'(vif.vec_mask), 128'd0);
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || vif.vec_valid) quiet = 1'b0;
        end
        check("t6_quiet", 128'(quiet), 128'd1);
        $display("xfer t6 reset mid-transfer complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pixel_vector_loader.md
# pixel_vector_loader

Sequencer between the colour ROM (`dataInMem`) and the vector register file load path. On `start` it sweeps a window of ROM addresses, one word per cycle, and packs consecutive pixels into `LANES`-wide vectors. Each vector is handed downstream over a valid/ready handshake. It drives the ROM `address` port and consumes its combinational `rd` output.

## Interface
- `WIDTH`, 24: pixel word width and ROM address width.
- `DEPTH`, 24: number of ROM words; addresses run 0..DEPTH-1.
- `LANES`, 4: pixels per output vector (≥1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `base_addr`  in  WIDTH  first ROM address; latched on accepted `start`.
- `count`  in  WIDTH  number of pixels to fetch; latched on accepted `start`.
- `mem_addr`  out  WIDTH  address to ROM.
- `mem_rd`  in  WIDTH  ROM read data, combinational from `mem_addr`.
- `vec_data`  out  LANES*WIDTH  packed vector; lane k at bits [k*WIDTH +: WIDTH].
- `vec_mask`  out  LANES  lane-valid bits.
- `vec_valid`  out  1  vector available.
- `vec_ready`  in  1  downstream accepts.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at end of transfer.

## Operation
- States: IDLE, FETCH, HOLD, DONE.
- **IDLE**
  - `start`=1 latches `base_addr` and `count` and clears the lane index.
  - Next state is FETCH, or DONE if `count`=0.
  - `start` in any other state is ignored.
- **FETCH**
  - `mem_addr` = current address.
  - Each clock edge writes `mem_rd` into lane[idx], sets mask[idx], increments idx and decrements remaining.
  - Next address = 0 if current = DEPTH-1, else current+1 (wrap).
  - Go to HOLD when idx reaches LANES or remaining reaches 0.
- **HOLD**
  - `vec_valid`=1.
  - `vec_data`, `vec_mask` and `mem_addr` are stable until the handshake.
  - On `vec_valid & vec_ready`: lanes and mask clear to 0 and idx to 0. Next state is FETCH if remaining > 0, else DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- A partial final vector has its unused lanes at 0 and their mask bits at 0.
- `base_addr` ≥ DEPTH is latched as 0.
- `count` may exceed DEPTH; addresses keep wrapping.

## Timing
- Reset: state IDLE. `mem_addr`, `vec_data`, `vec_mask`, `vec_valid`, `busy` and `done` are all 0. Internal counters are 0.
- `rst` has priority in every state. Asserting it mid-transfer drops the vector and returns to IDLE on the next edge with no `done`.
- Latency: start accepted at edge E0.
  - FETCH cycles are E0..E0+n.
  - `vec_valid` goes high after edge E0+n, where n = min(LANES, count).
  - Throughput: one pixel per cycle in FETCH.
- Handshake: `vec_valid` never drops without a handshake. `vec_ready` may be high before valid.
- Handshake on the last vector leads to `done` high in the following cycle.
- `count`=0: `done` is high the cycle after E0 and `vec_valid` never rises.

## Configuration
- `VLOAD_STALL_CNT_EN`
  - Defined: adds output `stall_cnt` (16 bits) that counts cycles in HOLD with `vec_ready`=0. It saturates at 0xFFFF, clears on accepted `start`, and resets to 0.
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `vload_pkg` holds:
  - the state enum `vload_state_t` (IDLE, FETCH, HOLD, DONE);
  - `STALL_CNT_W` = 16.
- One sub-module, `vload_addr_gen`: latches base and count, produces the wrapped address and the remaining count, and flags last/empty.
- The top level holds the FSM, the lane buffer and the handshake.

## Test plan
Bench uses WIDTH=24, DEPTH=24, LANES=4, ROM[i]=0x100+i.
- base=0, count=4, ready=1: one vector with lanes 0..3 = 0x100..0x103, mask 4'b1111; `done` pulses the cycle after the handshake.
- base=0, count=6: vector 1 is 0x100..0x103; vector 2 is lanes {0x104, 0x105, 0, 0} with mask 4'b0011; exactly one `done`.
- base=22, count=4: lanes = 0x116, 0x117, 0x100, 0x101 (address wrap 23→0).
- ready held low 10 cycles in HOLD: `vec_data` and `mem_addr` unchanged, `vec_valid` stays high; with the macro, `stall_cnt`=10.
- count=0: `busy` high 1 cycle, `done` pulse, `vec_valid` never high.
- `rst` after 2 FETCH cycles, plus a `start` pulse while busy: all outputs 0 next cycle; the mid-transfer `start` changes nothing.
